// File: rtl/seg_scan_ctrl_if.sv
// Handshake/bus bundle between a display client and seg_scan_ctrl.
// Latency: none; plain wires grouped for port convenience.
// Backpressure: none here; the client watches busy, and loads seen while busy are dropped.
//
// Signals:
//   value    [9:0]  unsigned amount to display (captured on an accepted load)
//   load            one-cycle convert request
//   blank_en        leading-zero blanking enable
//   disp_en         display enable (0 turns every anode off)
//   busy            conversion in progress
//   done            one-cycle pulse when new digits are latched
//   ovf             last loaded value was above 999 and got clamped
//   bcd_out  [3:0]  digit for the shared 7-segment decoder
//   an       [2:0]  active-low anodes: [0]=units, [1]=tens, [2]=hundreds
//
// Modports: master = the client driving requests, slave = seg_scan_ctrl.

interface seg_scan_ctrl_if;
   logic [9:0] value;
   logic       load;
   logic       blank_en;
   logic       disp_en;
   logic       busy;
   logic       done;
   logic       ovf;
   logic [3:0] bcd_out;
   logic [2:0] an;

   modport master (
      output value, load, blank_en, disp_en,
      input  busy, done, ovf, bcd_out, an
   );

   modport slave (
      input  value, load, blank_en, disp_en,
      output busy, done, ovf, bcd_out, an
   );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Binary-to-BCD converter plus 3-digit multiplexed 7-segment scan driver.
// Latency: load to done is 11 cycles (10 shift cycles); bcd_out/an lag slot select by 1 cycle.
// Backpressure: busy is high during conversion; loads arriving while busy are dropped, not queued.
//
// Ports:
//   clk    - single system clock, all state on the rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - seg_scan_ctrl_if.slave (value/load/blank_en/disp_en in,
//            busy/done/ovf/bcd_out/an out)
// Parameter:
//   REFRESH_DIV - clk cycles spent on each digit slot (2 .. 2**20)

module seg_scan_ctrl #(
   parameter int unsigned REFRESH_DIV = 100000
) (
   input  logic           clk,
   input  logic           rst_n,
   seg_scan_ctrl_if.slave bus
);

   localparam int unsigned   PW        = $clog2(REFRESH_DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
   localparam logic [PW-1:0] PRESC_ONE = PW'(1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      CONV = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      SLOT_U = 2'd0,
      SLOT_T = 2'd1,
      SLOT_H = 2'd2
   } slot_t;

   // ------------------------------------------------------------------
   // Conversion state
   // ------------------------------------------------------------------
   state_t      state;
   logic [3:0]  bit_cnt;
   logic [9:0]  bin_sr;
   // Only 11 BCD bits are held between shifts: the input is at most 999,
   // so before the last shift the partial result is at most 499 and the
   // hundreds nibble fits in 3 bits. Its 4th bit can only appear on the
   // final shift, which is taken straight from bcd_nxt.
   logic [10:0] bcd_sr;
   logic        ovf_pend;
   logic        busy_q;
   logic        done_q;
   logic        ovf_q;
   logic [3:0]  hund;
   logic [3:0]  tens;
   logic [3:0]  units;

   logic [9:0]  value_cl;
   logic        value_big;
   logic [7:0]  bcd_adj;
   logic [11:0] bcd_nxt;
   logic [9:0]  bin_nxt;

   // ------------------------------------------------------------------
   // Scan state
   // ------------------------------------------------------------------
   logic [PW-1:0] presc;
   slot_t         slot;
   logic [3:0]    bcd_q;
   logic [2:0]    an_q;

   logic [3:0]    sel_dig;
   logic [2:0]    sel_an;
   logic          sel_blank;

   // Clamp out-of-range amounts to 999; the overflow flag rides along
   // until the digits are published.
   always_comb begin
      value_big = (bus.value > 10'd999);
      value_cl  = value_big ? 10'd999 : bus.value;
   end

   // One double-dabble step: add 3 to any nibble >= 5, then shift the
   // BCD/binary pair left by one. The hundreds nibble never reaches 5
   // before a shift for inputs <= 999, so it needs no correction.
   always_comb begin
      bcd_adj = bcd_sr[7:0];
      if (bcd_sr[3:0] >= 4'd5) begin
         bcd_adj[3:0] = bcd_sr[3:0] + 4'd3;
      end
      if (bcd_sr[7:4] >= 4'd5) begin
         bcd_adj[7:4] = bcd_sr[7:4] + 4'd3;
      end
      bcd_nxt = {bcd_sr[10:8], bcd_adj, bin_sr[9]};
      bin_nxt = {bin_sr[8:0], 1'b0};
   end

   // Control FSM. Display digits are written only on the last shift so
   // the scan never shows partial results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         bit_cnt  <= 4'd0;
         bin_sr   <= 10'd0;
         bcd_sr   <= 11'd0;
         ovf_pend <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
         hund     <= 4'd0;
         tens     <= 4'd0;
         units    <= 4'd0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.load) begin
                  bin_sr   <= value_cl;
                  bcd_sr   <= 11'd0;
                  bit_cnt  <= 4'd0;
                  ovf_pend <= value_big;
                  busy_q   <= 1'b1;
                  state    <= CONV;
               end
            end
            CONV: begin
               bin_sr  <= bin_nxt;
               bcd_sr  <= bcd_nxt[10:0];
               bit_cnt <= bit_cnt + 4'd1;
               if (bit_cnt == 4'd9) begin
                  hund   <= bcd_nxt[11:8];
                  tens   <= bcd_nxt[7:4];
                  units  <= bcd_nxt[3:0];
                  ovf_q  <= ovf_pend;
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   // Slot decode: digit, anode pattern and leading-zero blanking.
   always_comb begin
      sel_dig   = units;
      sel_an    = 3'b110;
      sel_blank = 1'b0;
      case (slot)
         SLOT_T: begin
            sel_dig   = tens;
            sel_an    = 3'b101;
            sel_blank = bus.blank_en && (hund == 4'd0) && (tens == 4'd0);
         end
         SLOT_H: begin
            sel_dig   = hund;
            sel_an    = 3'b011;
            sel_blank = bus.blank_en && (hund == 4'd0);
         end
         default: begin
            sel_dig   = units;
            sel_an    = 3'b110;
            sel_blank = 1'b0;
         end
      endcase
   end

   // Free-running refresh scan, independent of conversion and disp_en.
   // bcd_out keeps carrying the selected digit even when the anodes are off.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
         slot  <= SLOT_U;
         bcd_q <= 4'd0;
         an_q  <= 3'b111;
      end else begin
         if (presc == PRESC_MAX) begin
            presc <= '0;
            case (slot)
               SLOT_U:  slot <= SLOT_T;
               SLOT_T:  slot <= SLOT_H;
               default: slot <= SLOT_U;
            endcase
         end else begin
            presc <= presc + PRESC_ONE;
         end
         bcd_q <= sel_dig;
         an_q  <= (!bus.disp_en || sel_blank) ? 3'b111 : sel_an;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.ovf     = ovf_q;
   assign bus.bcd_out = bcd_q;
   assign bus.an      = an_q;

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clk cycles per digit slot (legal range 2..2^20).
REQ-002 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port value  input  10  unsigned binary amount to display.
REQ-005 SHALL have port load  input  1  one-cycle request to convert and display value.
REQ-006 SHALL have port blank_en  input  1  leading-zero blanking enable.
REQ-007 SHALL have port disp_en  input  1  display enable; 0 forces all anodes off.
REQ-008 SHALL have port busy  output  1  conversion in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse, new digits latched.
REQ-010 SHALL have port ovf  output  1  last loaded value exceeded 999.
REQ-011 SHALL have port bcd_out  output  4  BCD digit for the shared bcd_to_7_seg decoder.
REQ-012 SHALL have port an  output  3  active-low digit anodes, an[0]=units, an[1]=tens, an[2]=hundreds.

Function
REQ-013 SHALL implement FSM states IDLE and CONV; IDLE->CONV on load=1 sampled in IDLE; CONV->IDLE after 10th shift.
REQ-014 SHALL capture value on the load edge; value>999 SHALL be replaced by 999 and ovf set to 1, else ovf cleared; ovf updates with done.
REQ-015 SHALL perform shift-add-3 (double dabble) conversion, exactly one bit shift per cycle, MSB first, 10 cycles in CONV.
REQ-016 busy SHALL be 1 for exactly the 10 cycles in CONV, starting the cycle after load is sampled.
REQ-017 Display digit registers (hund, tens, units) SHALL update and done SHALL pulse high in the first cycle after busy falls (load-to-done latency 11 cycles).
REQ-018 load while busy=1 SHALL be ignored; no queueing; load coincident with done cycle (IDLE) SHALL be accepted.
REQ-019 Display digit registers SHALL hold the previous value throughout CONV (no partial results shown).
REQ-020 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap; on terminal count slot select SHALL advance units->tens->hundreds->units.
REQ-021 Scanning SHALL run continuously regardless of FSM state, load or disp_en.
REQ-022 bcd_out and an SHALL be registered, reflecting slot select and digit registers of the previous cycle (1-cycle lag).
REQ-023 Active slot SHALL drive exactly one anode low: units 3'b110, tens 3'b101, hundreds 3'b011.
REQ-024 With blank_en=1: hundreds slot blanked when hund=0; tens slot blanked when hund=0 and tens=0; units never blanked.
REQ-025 Blanked slot or disp_en=0 SHALL drive an=3'b111; bcd_out still carries the selected digit.

Reset
REQ-026 rst_n=0 SHALL immediately force: FSM IDLE, busy=0, done=0, ovf=0, digits 0, prescaler 0, slot=units, bcd_out=4'd0, an=3'b111.
REQ-027 Reset asserted mid-conversion SHALL abort it; digits return to 0 and no done pulse follows.
REQ-028 First anode activation after reset release SHALL be units slot, one cycle after release (an=3'b110 if disp_en=1).

Verification (REFRESH_DIV=4)
REQ-029 Reset release, disp_en=1, blank_en=0 -> an sequence 110 (4 cycles), 101 (4), 011 (4), repeat; bcd_out=0 throughout.
REQ-030 load with value=10'd472 -> busy high 10 cycles, done pulse at cycle 11, ovf=0; slots show units=2, tens=7, hundreds=4.
REQ-031 load value=10'd1023 -> done after 11 cycles, ovf=1, digits 9,9,9; then load value=5 -> ovf=0.
REQ-032 load value=7, blank_en=1 -> hundreds and tens slots an=111, units slot an=110 bcd_out=7; value=0 -> only units lit showing 0.
REQ-033 Second load 3 cycles into conversion -> ignored, single done at cycle 11 with first value; load in done cycle -> accepted, busy next cycle.
REQ-034 rst_n pulsed low at busy cycle 5 -> outputs at reset values immediately, no done, display 0 after release; disp_en=0 -> an=111 while slot select keeps advancing.
